// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, reset PC and FSM state encoding.
package fetch_stage_pkg;

    localparam int DATASIZE = 32;
    localparam int PCSIZE   = 16;
    localparam int RESET_PC = 0;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_skid.sv
// One-entry holding buffer for an instruction (and its PC) that arrived while IF/ID was stalled.
module fetch_skid
    import fetch_stage_pkg::*;
#(
    parameter int DATA_W = DATASIZE,
    parameter int PC_W   = PCSIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] new_instr,
    input  logic [PC_W-1:0]   new_pc,
    output logic              full,
    output logic [DATA_W-1:0] instr,
    output logic [PC_W-1:0]   pc
);

    // Clear wins over load so a redirect always discards the held instruction.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= new_instr;
            pc    <= new_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a 1-cycle synchronous ROM and feeds the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int DATA_W   = DATASIZE,
    parameter int PC_W     = PCSIZE,
    parameter int RESET_PC = fetch_stage_pkg::RESET_PC,
    parameter int PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              ifid_wr,
    output logic              ifid_valid,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [PC_W-1:0]   ifid_pc
);

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic              sk_load, sk_clear, sk_full;
    logic [DATA_W-1:0] sk_instr;
    logic [PC_W-1:0]   sk_pc;

    fetch_skid #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (sk_load),
        .clear     (sk_clear),
        .new_instr (imem_rdata),
        .new_pc    (req_pc_q),
        .full      (sk_full),
        .instr     (sk_instr),
        .pc        (sk_pc)
    );

    assign imem_addr = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= PC_W'(RESET_PC);
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    // Priority: reset, then redirect (kills anything in flight or held), then stall, then normal fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = inflight_q;
        sk_load    = 1'b0;
        sk_clear   = 1'b0;
        imem_req   = 1'b0;
        ifid_wr    = 1'b0;
        ifid_valid = 1'b0;
        ifid_instr = '0;
        ifid_pc    = '0;
        if (rst) begin
            sk_clear = 1'b1;
        end else if (redirect) begin
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
            sk_clear   = 1'b1;
            state_d    = RUN;
            ifid_wr    = 1'b1;
        end else if (stall) begin
            if (state_q == RUN) begin
                inflight_d = 1'b0;
                if (inflight_q) begin
                    sk_load = 1'b1;
                    state_d = HOLD;
                end
            end
        end else begin
            imem_req   = 1'b1;
            pc_d       = pc_q + PC_W'(PC_STEP);
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
            ifid_wr    = 1'b1;
            if (state_q == HOLD) begin
                // The ROM output is stale here; the held copy is the one owed to IF/ID.
                ifid_valid = sk_full;
                ifid_instr = sk_instr;
                ifid_pc    = sk_pc;
                sk_clear   = 1'b1;
                state_d    = RUN;
            end else if (inflight_q) begin
                ifid_valid = 1'b1;
                ifid_instr = imem_rdata;
                ifid_pc    = req_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage: two instances (PC_W=16 and PC_W=4) checked every cycle against an
// "owed instruction" model, plus directed scenarios with hand-computed expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;

    logic        req_a, wr_a, valid_a;
    logic [15:0] addr_a, pc_a;
    logic [31:0] rdata_a, instr_a;
    logic        req_b, wr_b, valid_b;
    logic [3:0]  addr_b, pc_b;
    logic [31:0] rdata_b, instr_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_stage #(.DATA_W(32), .PC_W(16)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
        .ifid_wr(wr_a), .ifid_valid(valid_a), .ifid_instr(instr_a), .ifid_pc(pc_a)
    );

    fetch_stage #(.DATA_W(32), .PC_W(4)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc[3:0]),
        .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .ifid_wr(wr_b), .ifid_valid(valid_b), .ifid_instr(instr_b), .ifid_pc(pc_b)
    );

    function automatic logic [31:0] rom(int a);
        return 32'(a) + 32'h100;
    endfunction

    // ROM with 1-cycle latency; garbage when no request so a stale read would be noticed.
    always @(posedge clk) begin
        rdata_a <= req_a ? rom(int'(addr_a)) : $urandom;
        rdata_b <= req_b ? rom(int'(addr_b)) : $urandom;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic d, input logic [15:0] t);
        @(posedge clk);
        #1;
        rst = r;
        stall = s;
        redirect = d;
        redirect_pc = t;
        @(negedge clk);
    endtask

    // Model: next address to fetch, and at most one fetched-but-undelivered instruction owed to IF/ID.
    int  m_next[2]    = '{0, 0};
    bit  m_owed[2]    = '{0, 0};
    int  m_owed_pc[2] = '{0, 0};
    int  m_mask[2]    = '{32'hFFFF, 32'hF};

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic        e_req, e_wr, e_valid, a_req, a_wr, a_valid;
                logic [31:0] e_instr, e_pc, a_instr, a_pc, a_addr;
                string       tag;
                tag = (i == 0) ? "a" : "b";
                if (i == 0) begin
                    a_req = req_a; a_wr = wr_a; a_valid = valid_a;
                    a_instr = instr_a; a_pc = 32'(pc_a); a_addr = 32'(addr_a);
                end else begin
                    a_req = req_b; a_wr = wr_b; a_valid = valid_b;
                    a_instr = instr_b; a_pc = 32'(pc_b); a_addr = 32'(addr_b);
                end
                e_req = 0; e_wr = 0; e_valid = 0; e_instr = 0; e_pc = 0;
                if (rst) begin
                end else if (redirect) begin
                    e_wr = 1;
                end else if (!stall) begin
                    e_req = 1;
                    e_wr = 1;
                    if (m_owed[i]) begin
                        e_valid = 1;
                        e_pc = 32'(m_owed_pc[i]);
                        e_instr = rom(m_owed_pc[i]);
                    end
                end
                checkOutput({"model_req_", tag}, 32'(a_req), 32'(e_req));
                checkOutput({"model_wr_", tag}, 32'(a_wr), 32'(e_wr));
                checkOutput({"model_valid_", tag}, 32'(a_valid), 32'(e_valid));
                checkOutput({"model_instr_", tag}, a_instr, e_instr);
                checkOutput({"model_pc_", tag}, a_pc, e_pc);
                if (e_req) checkOutput({"model_addr_", tag}, a_addr, 32'(m_next[i]));
                if (rst) begin
                    m_owed[i] = 0;
                    m_next[i] = 0;
                end else if (redirect) begin
                    m_owed[i] = 0;
                    m_next[i] = int'(redirect_pc) & m_mask[i];
                end else if (!stall) begin
                    m_owed[i] = 1;
                    m_owed_pc[i] = m_next[i];
                    m_next[i] = (m_next[i] + 1) & m_mask[i];
                end
            end
        end
    end

    initial begin
        int exp5[4];
        exp5 = '{14, 15, 0, 1};

        applyStimulus(1, 0, 0, 16'h0);
        checkOutput("rst_req", 32'(req_a), 0);
        checkOutput("rst_wr", 32'(wr_a), 0);
        applyStimulus(1, 0, 0, 16'h0);

        // Startup: first request at 0, first valid one cycle later.
        applyStimulus(0, 0, 0, 16'h0);
        checkOutput("t1_addr0", 32'(addr_a), 0);
        checkOutput("t1_valid0", 32'(valid_a), 0);
        applyStimulus(0, 0, 0, 16'h0);
        checkOutput("t1_addr1", 32'(addr_a), 1);
        checkOutput("t1_valid1", 32'(valid_a), 1);
        checkOutput("t1_instr", instr_a, 32'h100);
        checkOutput("t1_pc", 32'(pc_a), 0);
        for (int k = 2; k <= 4; k++) applyStimulus(0, 0, 0, 16'h0);
        checkOutput("t2_addr4", 32'(addr_a), 4);
        checkOutput("t2_pc3", 32'(pc_a), 3);

        // Stall with pc 4 in flight, then release: 4 then 5.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 0, 16'h0);
            checkOutput("t2_stall_req", 32'(req_a), 0);
            checkOutput("t2_stall_wr", 32'(wr_a), 0);
        end
        applyStimulus(0, 0, 0, 16'h0);
        checkOutput("t2_rel_pc4", 32'(pc_a), 4);
        checkOutput("t2_rel_instr", instr_a, 32'h104);
        checkOutput("t2_rel_addr5", 32'(addr_a), 5);
        applyStimulus(0, 0, 0, 16'h0);
        checkOutput("t2_rel_pc5", 32'(pc_a), 5);
        applyStimulus(0, 0, 0, 16'h0);

        // Redirect to 0x40 while pc 7 is in flight.
        applyStimulus(0, 0, 1, 16'h40);
        checkOutput("t3_bub_wr", 32'(wr_a), 1);
        checkOutput("t3_bub_valid", 32'(valid_a), 0);
        checkOutput("t3_bub_req", 32'(req_a), 0);
        applyStimulus(0, 0, 0, 16'h0);
        checkOutput("t3_addr40", 32'(addr_a), 32'h40);
        checkOutput("t3_valid0", 32'(valid_a), 0);
        applyStimulus(0, 0, 0, 16'h0);
        checkOutput("t3_pc40", 32'(pc_a), 32'h40);
        checkOutput("t3_instr", instr_a, 32'h140);

        // Redirect and stall together while holding pc 0x41.
        applyStimulus(0, 1, 0, 16'h0);
        applyStimulus(0, 1, 1, 16'h80);
        checkOutput("t4_bub_wr", 32'(wr_a), 1);
        checkOutput("t4_bub_valid", 32'(valid_a), 0);
        applyStimulus(0, 1, 0, 16'h0);
        checkOutput("t4_stall_wr", 32'(wr_a), 0);
        applyStimulus(0, 0, 0, 16'h0);
        checkOutput("t4_addr80", 32'(addr_a), 32'h80);
        checkOutput("t4_valid0", 32'(valid_a), 0);
        applyStimulus(0, 0, 0, 16'h0);
        checkOutput("t4_pc80", 32'(pc_a), 32'h80);

        // 4-bit PC wraps 15 -> 0.
        applyStimulus(0, 0, 1, 16'h0E);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 16'h0);
            checkOutput("t5_addr_b", 32'(addr_b), 32'(exp5[k]));
        end

        // Reset while holding: outputs zero, held instruction dropped.
        applyStimulus(0, 1, 0, 16'h0);
        applyStimulus(1, 1, 0, 16'h0);
        checkOutput("t6_req", 32'(req_a), 0);
        checkOutput("t6_wr", 32'(wr_a), 0);
        checkOutput("t6_valid", 32'(valid_a), 0);
        checkOutput("t6_instr", instr_a, 0);
        checkOutput("t6_pc", 32'(pc_a), 0);
        applyStimulus(0, 0, 0, 16'h0);
        checkOutput("t6_addr0", 32'(addr_a), 0);
        checkOutput("t6_valid0", 32'(valid_a), 0);
        applyStimulus(0, 0, 0, 16'h0);
        checkOutput("t6_pc0", 32'(pc_a), 0);
        checkOutput("t6_instr0", instr_a, 32'h100);

        for (int k = 0; k < 600; k++) begin
            applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 10, 16'($urandom));
        end
        applyStimulus(0, 0, 0, 16'h0);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
